// File: rtl/light_source_arbiter_if.sv
// Source-side request/ack signals and lamp-driver outputs of the light source arbiter.
// master = source logic and lamp driver side; slave = arbiter.
interface light_source_arbiter_if;
    logic       man_valid;
    logic [1:0] man_lum;
    logic [1:0] man_color;
    logic       rem_valid;
    logic [1:0] rem_lum;
    logic [1:0] rem_color;
    logic [1:0] auto_lum;
    logic [1:0] auto_color;
    logic       man_ack;
    logic       rem_ack;
    logic       rem_nack;
    logic [1:0] owner;
    logic [1:0] lum_out;
    logic [1:0] color_out;
    logic       ramping;

    modport master (
        output man_valid, man_lum, man_color,
        output rem_valid, rem_lum, rem_color,
        output auto_lum, auto_color,
        input  man_ack, rem_ack, rem_nack,
        input  owner, lum_out, color_out, ramping
    );

    modport slave (
        input  man_valid, man_lum, man_color,
        input  rem_valid, rem_lum, rem_color,
        input  auto_lum, auto_color,
        output man_ack, rem_ack, rem_nack,
        output owner, lum_out, color_out, ramping
    );
endinterface

// File: rtl/light_source_arbiter.sv
// Arbitrates one lamp between manual, remote and automatic sources with timed
// ownership holds and a tick-paced one-step luminosity ramp.
module light_source_arbiter #(
    parameter int unsigned PRESCALE   = 1000,
    parameter int unsigned MAN_HOLD   = 60,
    parameter int unsigned REM_HOLD   = 30,
    parameter int unsigned RAMP_TICKS = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    light_source_arbiter_if.slave  bus
);
    localparam int unsigned PW = $clog2(PRESCALE + 1);
    localparam int unsigned MW = $clog2(MAN_HOLD + 1);
    localparam int unsigned RW = $clog2(REM_HOLD + 1);
    localparam int unsigned TW = $clog2(RAMP_TICKS + 1);

    typedef enum logic [1:0] {
        OWN_AUTO   = 2'b00,
        OWN_REMOTE = 2'b01,
        OWN_MANUAL = 2'b10
    } owner_t;

    owner_t        owner_q, owner_d;
    logic [PW-1:0] pre_cnt;
    logic          tick;
    logic [MW-1:0] man_cnt;
    logic [RW-1:0] rem_cnt;
    logic [TW-1:0] ramp_cnt, ramp_d;
    logic [1:0]    man_lum_q, man_color_q, rem_lum_q, rem_color_q;
    logic [1:0]    tgt_lum, tgt_color;
    logic [1:0]    lum_q, lum_d, color_q;
    logic          ramping_q;
    logic          man_hit, rem_hit, rem_miss;
    logic          man_acc_q, rem_acc_q, rem_rej_q;
    logic          man_ack_q, rem_ack_q, rem_nack_q;

    assign tick     = (pre_cnt == PW'(PRESCALE - 1));
    assign man_hit  = bus.man_valid;
    assign rem_hit  = bus.rem_valid && !bus.man_valid && (owner_q != OWN_MANUAL);
    assign rem_miss = bus.rem_valid && !rem_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    // A load on the same cycle as a tick takes precedence over the decrement.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            man_cnt     <= '0;
            rem_cnt     <= '0;
            man_lum_q   <= '0;
            man_color_q <= '0;
            rem_lum_q   <= '0;
            rem_color_q <= '0;
        end else begin
            if (man_hit) begin
                man_cnt     <= MW'(MAN_HOLD);
                man_lum_q   <= bus.man_lum;
                man_color_q <= bus.man_color;
            end else if (tick && man_cnt != '0) begin
                man_cnt <= man_cnt - MW'(1);
            end
            if (rem_hit) begin
                rem_cnt     <= RW'(REM_HOLD);
                rem_lum_q   <= bus.rem_lum;
                rem_color_q <= bus.rem_color;
            end else if (tick && rem_cnt != '0) begin
                rem_cnt <= rem_cnt - RW'(1);
            end
        end
    end

    // Acceptance is staged once more so each ack lands with the owner change it caused.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            man_acc_q  <= 1'b0;
            rem_acc_q  <= 1'b0;
            rem_rej_q  <= 1'b0;
            man_ack_q  <= 1'b0;
            rem_ack_q  <= 1'b0;
            rem_nack_q <= 1'b0;
        end else begin
            man_acc_q  <= man_hit;
            rem_acc_q  <= rem_hit;
            rem_rej_q  <= rem_miss;
            man_ack_q  <= man_acc_q;
            rem_ack_q  <= rem_acc_q;
            rem_nack_q <= rem_rej_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q <= OWN_AUTO;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        owner_d = OWN_AUTO;
        if (man_cnt != '0) begin
            owner_d = OWN_MANUAL;
        end else if (rem_cnt != '0) begin
            owner_d = OWN_REMOTE;
        end
    end

    always_comb begin
        tgt_lum   = bus.auto_lum;
        tgt_color = bus.auto_color;
        case (owner_q)
            OWN_MANUAL: begin
                tgt_lum   = man_lum_q;
                tgt_color = man_color_q;
            end
            OWN_REMOTE: begin
                tgt_lum   = rem_lum_q;
                tgt_color = rem_color_q;
            end
            default: ;
        endcase
    end

    // Stepping only toward an in-range target keeps lum_out within 00..11.
    always_comb begin
        lum_d  = lum_q;
        ramp_d = ramp_cnt;
        if (lum_q == tgt_lum) begin
            ramp_d = '0;
        end else if (tick) begin
            if (ramp_cnt == TW'(RAMP_TICKS - 1)) begin
                ramp_d = '0;
                lum_d  = (lum_q < tgt_lum) ? lum_q + 2'd1 : lum_q - 2'd1;
            end else begin
                ramp_d = ramp_cnt + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lum_q     <= '0;
            ramp_cnt  <= '0;
            ramping_q <= 1'b0;
            color_q   <= '0;
        end else begin
            lum_q     <= lum_d;
            ramp_cnt  <= ramp_d;
            ramping_q <= (lum_d != tgt_lum);
            color_q   <= tgt_color;
        end
    end

    assign bus.man_ack   = man_ack_q;
    assign bus.rem_ack   = rem_ack_q;
    assign bus.rem_nack  = rem_nack_q;
    assign bus.owner     = owner_q;
    assign bus.lum_out   = lum_q;
    assign bus.color_out = color_q;
    assign bus.ramping   = ramping_q;
endmodule

// File: tb/tb_light_source_arbiter.sv
// Directed self-checking bench for light_source_arbiter; three instances cover
// the default, long-remote-hold and slow-ramp parameter sets.
module tb_light_source_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    light_source_arbiter_if ia();
    light_source_arbiter_if ib();
    light_source_arbiter_if ic();

    light_source_arbiter #(.PRESCALE(4), .MAN_HOLD(3), .REM_HOLD(2), .RAMP_TICKS(1))
        dut_a (.clk(clk), .reset(reset), .bus(ia));
    light_source_arbiter #(.PRESCALE(4), .MAN_HOLD(3), .REM_HOLD(8), .RAMP_TICKS(1))
        dut_b (.clk(clk), .reset(reset), .bus(ib));
    light_source_arbiter #(.PRESCALE(4), .MAN_HOLD(3), .REM_HOLD(2), .RAMP_TICKS(3))
        dut_c (.clk(clk), .reset(reset), .bus(ic));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_inputs();
        ia.man_valid = 0; ia.man_lum = 0; ia.man_color = 0;
        ia.rem_valid = 0; ia.rem_lum = 0; ia.rem_color = 0;
        ia.auto_lum = 0; ia.auto_color = 0;
        ib.man_valid = 0; ib.man_lum = 0; ib.man_color = 0;
        ib.rem_valid = 0; ib.rem_lum = 0; ib.rem_color = 0;
        ib.auto_lum = 0; ib.auto_color = 0;
        ic.man_valid = 0; ic.man_lum = 0; ic.man_color = 0;
        ic.rem_valid = 0; ic.rem_lum = 0; ic.rem_color = 0;
        ic.auto_lum = 0; ic.auto_color = 0;
    endtask

    // Leaves reset low at a falling edge; the caller releases it there (edge count 0).
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        wait_neg(2);
    endtask

    task automatic test_reset();
        ia.man_valid = 1; ib.rem_valid = 1; ic.auto_lum = 3; ic.auto_color = 2;
        wait_neg(3);
        checks++; if (ia.owner !== 2'b00 || ia.lum_out !== 2'b00 || ia.color_out !== 2'b00) begin errors++; $display("FAIL reset_a: owner %0h lum %0h color %0h expected 0 0 0", ia.owner, ia.lum_out, ia.color_out); end
        checks++; if (ia.man_ack !== 1'b0 || ia.rem_ack !== 1'b0 || ia.rem_nack !== 1'b0 || ia.ramping !== 1'b0) begin errors++; $display("FAIL reset_a_pulses: man_ack %0b rem_ack %0b rem_nack %0b ramping %0b expected 0", ia.man_ack, ia.rem_ack, ia.rem_nack, ia.ramping); end
        checks++; if (ib.rem_nack !== 1'b0 || ib.owner !== 2'b00) begin errors++; $display("FAIL reset_b: rem_nack %0b owner %0h expected 0 0", ib.rem_nack, ib.owner); end
        checks++; if (ic.color_out !== 2'b00 || ic.lum_out !== 2'b00 || ic.ramping !== 1'b0) begin errors++; $display("FAIL reset_c: color %0h lum %0h ramping %0b expected 0 0 0", ic.color_out, ic.lum_out, ic.ramping); end
    endtask

    task automatic test_auto_ramp();
        apply_reset();
        ia.auto_lum = 2'b11; ia.auto_color = 2'b10;
        reset = 1'b1;
        checks++; if (ia.color_out !== 2'b00) begin errors++; $display("FAIL auto_color_e0: got %0h expected 0", ia.color_out); end
        wait_neg(1);
        checks++; if (ia.color_out !== 2'b10 || ia.owner !== 2'b00 || ia.lum_out !== 2'b00) begin errors++; $display("FAIL auto_e1: color %0h owner %0h lum %0h expected 2 0 0", ia.color_out, ia.owner, ia.lum_out); end
        checks++; if (ia.ramping !== 1'b1) begin errors++; $display("FAIL auto_ramping_e1: got %0b expected 1", ia.ramping); end
        wait_neg(2);
        checks++; if (ia.lum_out !== 2'b00) begin errors++; $display("FAIL auto_lum_e3: got %0h expected 0", ia.lum_out); end
        wait_neg(1);
        checks++; if (ia.lum_out !== 2'b01) begin errors++; $display("FAIL auto_lum_e4: got %0h expected 1", ia.lum_out); end
        wait_neg(4);
        checks++; if (ia.lum_out !== 2'b10) begin errors++; $display("FAIL auto_lum_e8: got %0h expected 2", ia.lum_out); end
        wait_neg(4);
        checks++; if (ia.lum_out !== 2'b11 || ia.ramping !== 1'b0) begin errors++; $display("FAIL auto_lum_e12: lum %0h ramping %0b expected 3 0", ia.lum_out, ia.ramping); end
        wait_neg(4);
        checks++; if (ia.lum_out !== 2'b11) begin errors++; $display("FAIL auto_saturate: got %0h expected 3", ia.lum_out); end
    endtask

    task automatic test_remote_hold();
        apply_reset();
        reset = 1'b1;
        wait_neg(1);
        ia.rem_valid = 1; ia.rem_lum = 2'b01; ia.rem_color = 2'b01;
        wait_neg(1);
        ia.rem_valid = 0;
        checks++; if (ia.rem_ack !== 1'b0 || ia.owner !== 2'b00) begin errors++; $display("FAIL rem_e2: rem_ack %0b owner %0h expected 0 0", ia.rem_ack, ia.owner); end
        wait_neg(1);
        checks++; if (ia.rem_ack !== 1'b1 || ia.rem_nack !== 1'b0 || ia.owner !== 2'b01) begin errors++; $display("FAIL rem_e3: rem_ack %0b rem_nack %0b owner %0h expected 1 0 1", ia.rem_ack, ia.rem_nack, ia.owner); end
        wait_neg(1);
        checks++; if (ia.rem_ack !== 1'b0 || ia.lum_out !== 2'b01 || ia.color_out !== 2'b01) begin errors++; $display("FAIL rem_e4: rem_ack %0b lum %0h color %0h expected 0 1 1", ia.rem_ack, ia.lum_out, ia.color_out); end
        wait_neg(4);
        checks++; if (ia.owner !== 2'b01) begin errors++; $display("FAIL rem_owner_e8: got %0h expected 1", ia.owner); end
        wait_neg(1);
        checks++; if (ia.owner !== 2'b00) begin errors++; $display("FAIL rem_owner_e9: got %0h expected 0", ia.owner); end
        wait_neg(3);
        checks++; if (ia.lum_out !== 2'b00 || ia.color_out !== 2'b00) begin errors++; $display("FAIL rem_back_auto_e12: lum %0h color %0h expected 0 0", ia.lum_out, ia.color_out); end
    endtask

    task automatic test_collision();
        apply_reset();
        reset = 1'b1;
        wait_neg(1);
        ib.man_valid = 1; ib.man_lum = 2'b10; ib.man_color = 2'b11;
        ib.rem_valid = 1; ib.rem_lum = 2'b01; ib.rem_color = 2'b01;
        wait_neg(1);
        ib.man_valid = 0; ib.rem_valid = 0;
        wait_neg(1);
        checks++; if (ib.man_ack !== 1'b1 || ib.rem_nack !== 1'b1 || ib.rem_ack !== 1'b0 || ib.owner !== 2'b10) begin errors++; $display("FAIL coll_e3: man_ack %0b rem_nack %0b rem_ack %0b owner %0h expected 1 1 0 2", ib.man_ack, ib.rem_nack, ib.rem_ack, ib.owner); end
        wait_neg(1);
        checks++; if (ib.man_ack !== 1'b0 || ib.rem_nack !== 1'b0 || ib.color_out !== 2'b11 || ib.lum_out !== 2'b01) begin errors++; $display("FAIL coll_e4: man_ack %0b rem_nack %0b color %0h lum %0h expected 0 0 3 1", ib.man_ack, ib.rem_nack, ib.color_out, ib.lum_out); end
        wait_neg(4);
        checks++; if (ib.lum_out !== 2'b10) begin errors++; $display("FAIL coll_lum_e8: got %0h expected 2", ib.lum_out); end
        wait_neg(4);
        checks++; if (ib.owner !== 2'b10) begin errors++; $display("FAIL coll_owner_e12: got %0h expected 2", ib.owner); end
        wait_neg(1);
        checks++; if (ib.owner !== 2'b00) begin errors++; $display("FAIL coll_owner_e13: got %0h expected 0 (remote must not be loaded)", ib.owner); end
    endtask

    task automatic test_manual_over_remote();
        apply_reset();
        reset = 1'b1;
        wait_neg(1);
        ib.rem_valid = 1; ib.rem_lum = 2'b01; ib.rem_color = 2'b01;
        wait_neg(1);
        ib.rem_valid = 0;
        wait_neg(1);
        checks++; if (ib.owner !== 2'b01) begin errors++; $display("FAIL mor_owner_e3: got %0h expected 1", ib.owner); end
        ib.man_valid = 1; ib.man_lum = 2'b11; ib.man_color = 2'b10;
        wait_neg(1);
        ib.man_valid = 0;
        wait_neg(1);
        checks++; if (ib.owner !== 2'b10 || ib.man_ack !== 1'b1) begin errors++; $display("FAIL mor_e5: owner %0h man_ack %0b expected 2 1", ib.owner, ib.man_ack); end
        wait_neg(1);
        checks++; if (ib.color_out !== 2'b10) begin errors++; $display("FAIL mor_color_e6: got %0h expected 2", ib.color_out); end
        wait_neg(3);
        ib.rem_valid = 1; ib.rem_lum = 2'b10; ib.rem_color = 2'b10;
        wait_neg(1);
        ib.rem_valid = 0;
        wait_neg(1);
        checks++; if (ib.rem_nack !== 1'b1 || ib.rem_ack !== 1'b0 || ib.owner !== 2'b10) begin errors++; $display("FAIL mor_reject_e11: rem_nack %0b rem_ack %0b owner %0h expected 1 0 2", ib.rem_nack, ib.rem_ack, ib.owner); end
        wait_neg(5);
        checks++; if (ib.owner !== 2'b10) begin errors++; $display("FAIL mor_owner_e16: got %0h expected 2", ib.owner); end
        wait_neg(1);
        checks++; if (ib.owner !== 2'b01) begin errors++; $display("FAIL mor_owner_e17: got %0h expected 1", ib.owner); end
        wait_neg(1);
        checks++; if (ib.color_out !== 2'b01) begin errors++; $display("FAIL mor_restore_color_e18: got %0h expected 1", ib.color_out); end
        wait_neg(14);
        checks++; if (ib.owner !== 2'b01) begin errors++; $display("FAIL mor_owner_e32: got %0h expected 1", ib.owner); end
        wait_neg(1);
        checks++; if (ib.owner !== 2'b00) begin errors++; $display("FAIL mor_owner_e33: got %0h expected 0", ib.owner); end
    endtask

    task automatic test_ramp_reverse();
        apply_reset();
        ic.auto_lum = 2'b11;
        reset = 1'b1;
        wait_neg(11);
        checks++; if (ic.lum_out !== 2'b00) begin errors++; $display("FAIL rev_lum_e11: got %0h expected 0", ic.lum_out); end
        wait_neg(1);
        checks++; if (ic.lum_out !== 2'b01 || ic.ramping !== 1'b1) begin errors++; $display("FAIL rev_e12: lum %0h ramping %0b expected 1 1", ic.lum_out, ic.ramping); end
        wait_neg(4);
        ic.auto_lum = 2'b00;
        wait_neg(7);
        checks++; if (ic.lum_out !== 2'b01) begin errors++; $display("FAIL rev_lum_e23: got %0h expected 1", ic.lum_out); end
        wait_neg(1);
        checks++; if (ic.lum_out !== 2'b00 || ic.ramping !== 1'b0) begin errors++; $display("FAIL rev_e24: lum %0h ramping %0b expected 0 0", ic.lum_out, ic.ramping); end
        wait_neg(16);
        checks++; if (ic.lum_out !== 2'b00 || ic.ramping !== 1'b0) begin errors++; $display("FAIL rev_settled_e40: lum %0h ramping %0b expected 0 0", ic.lum_out, ic.ramping); end
    endtask

    task automatic test_reset_mid_hold();
        apply_reset();
        reset = 1'b1;
        wait_neg(1);
        ia.man_valid = 1; ia.man_lum = 2'b10; ia.man_color = 2'b01;
        wait_neg(1);
        ia.man_valid = 0;
        wait_neg(7);
        checks++; if (ia.lum_out !== 2'b10 || ia.owner !== 2'b10 || ia.color_out !== 2'b01) begin errors++; $display("FAIL hold_e9: lum %0h owner %0h color %0h expected 2 2 1", ia.lum_out, ia.owner, ia.color_out); end
        #2 reset = 1'b0;
        #1;
        checks++; if (ia.owner !== 2'b00 || ia.lum_out !== 2'b00 || ia.color_out !== 2'b00 || ia.ramping !== 1'b0) begin errors++; $display("FAIL async_reset: owner %0h lum %0h color %0h ramping %0b expected 0 0 0 0", ia.owner, ia.lum_out, ia.color_out, ia.ramping); end
        @(negedge clk);
        reset = 1'b1;
        wait_neg(1);
        checks++; if (ia.owner !== 2'b00) begin errors++; $display("FAIL post_reset_owner_e1: got %0h expected 0", ia.owner); end
        wait_neg(4);
        checks++; if (ia.owner !== 2'b00 || ia.lum_out !== 2'b00) begin errors++; $display("FAIL post_reset_e5: owner %0h lum %0h expected 0 0", ia.owner, ia.lum_out); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        clear_inputs();
        test_reset();
        test_auto_ramp();
        test_remote_hold();
        test_collision();
        test_manual_over_remote();
        test_ramp_reverse();
        test_reset_mid_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
